polar_to_rect_cordic: RTL

- Iterative CORDIC rotator that converts a polar pair (magnitude, angle) into signed rectangular components (X, Y).
- It is the inverse companion of the team's magnitude calculator, which maps (X, Y) to an approximate sqrt(X²+Y²). This block maps a magnitude and angle back to components.
- It sits behind a valid/ready input port and in front of a valid/ready output port, and processes one conversion at a time.

---
 rtl/cordic_pkg.sv | 33 +++
 rtl/cordic_stage.sv | 44 ++++
 rtl/polar_to_rect_cordic.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/cordic_pkg.sv
// Shared constants and types for the polar-to-rectangular CORDIC rotator.
//   ATAN lookup : arctan(2^-i) in angle units where a full turn is 4096.
//   INV_GAIN    : 155/256, approximately 1/K, applied to the magnitude before rotating.
//   FRAC        : number of fractional bits in the x/y datapath.
//   state_e     : controller states.
package cordic_pkg;

  localparam int unsigned INV_GAIN = 155;
  localparam int unsigned FRAC     = 4;

  typedef enum logic [1:0] {
    StIdle,
    StIter,
    StDone
  } state_e;

  // arctan(2^-idx) scaled so that 4096 is one full turn.
  function automatic logic [9:0] atan_lut(input logic [2:0] idx);
    logic [9:0] val;
    case (idx)
      3'd0:    val = 10'd512;
      3'd1:    val = 10'd302;
      3'd2:    val = 10'd160;
      3'd3:    val = 10'd81;
      3'd4:    val = 10'd41;
      3'd5:    val = 10'd20;
      3'd6:    val = 10'd10;
      default: val = 10'd5;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/cordic_stage.sv
// One combinational CORDIC micro-rotation in rotation mode.
//   x, y   : current vector (signed, DW bits, FRAC fractional bits)
//   z      : residual angle (signed, AW bits, 4096 = full turn)
//   idx    : iteration index i, selecting the shift amount and the arctan entry
//   x_rot, y_rot, z_rot : vector and residual angle after the micro-rotation
module cordic_stage
  import cordic_pkg::*;
#(
  parameter int unsigned DW = 14,
  parameter int unsigned AW = 12
) (
  input  logic [DW-1:0] x,
  input  logic [DW-1:0] y,
  input  logic [AW-1:0] z,
  input  logic [2:0]    idx,
  output logic [DW-1:0] x_rot,
  output logic [DW-1:0] y_rot,
  output logic [AW-1:0] z_rot
);

  logic signed [DW-1:0] xs, ys, x_sh, y_sh;
  logic signed [AW-1:0] zs, step;

  assign xs   = x;
  assign ys   = y;
  assign zs   = z;
  assign x_sh = xs >>> idx;
  assign y_sh = ys >>> idx;
  assign step = AW'(atan_lut(idx));

  // Rotate toward z = 0: counter-clockwise while the residual is non-negative.
  always_comb begin
    if (zs[AW-1]) begin
      x_rot = xs + y_sh;
      y_rot = ys - x_sh;
      z_rot = zs + step;
    end else begin
      x_rot = xs - y_sh;
      y_rot = ys + x_sh;
      z_rot = zs - step;
    end
  end

endmodule

// File: rtl/polar_to_rect_cordic.sv
// Iterative CORDIC rotator: (magnitude, angle) -> signed (X, Y).
// One conversion at a time behind valid/ready handshakes on both sides.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : request handshake; mag_in (0..255), angle_in (256 = full turn)
//   out_valid/out_ready : result handshake; x_out, y_out signed, saturated to +/-255
module polar_to_rect_cordic
  import cordic_pkg::*;
#(
  parameter int unsigned ITER = 8,
  parameter int unsigned DW   = 14,
  parameter int unsigned AW   = 12
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] mag_in,
  input  logic [7:0] angle_in,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [8:0] x_out,
  output logic [8:0] y_out
);

  localparam logic [3:0]         LastIter  = 4'(ITER);
  localparam logic [AW-1:0]      HalfTurn  = AW'(1) << (AW - 1);
  localparam logic signed [DW:0] SatHi     = (DW + 1)'(255);
  localparam logic signed [DW:0] SatLo     = -SatHi;
  localparam logic signed [DW:0] RoundBias = (DW + 1)'(1 << (FRAC - 1));

  state_e               state_q, state_d;
  logic signed [DW-1:0] x_q, x_d, y_q, y_d;
  logic signed [AW-1:0] z_q, z_d;
  logic [3:0]           iter_q, iter_d;
  logic [8:0]           x_out_q, x_out_d, y_out_q, y_out_d;

  // Capture path: pre-scale by 1/K and fold the left half-plane onto the right.
  logic [15:0]          mag_prod;
  logic signed [DW-1:0] m0, x_init;
  logic [AW-1:0]        a_wide, z_init;
  logic                 fold;

  assign mag_prod = 16'(mag_in) * 16'(INV_GAIN);
  assign m0       = DW'(mag_prod >> FRAC);
  assign a_wide   = AW'(angle_in) << (AW - 8);
  assign fold     = angle_in[7] ^ angle_in[6];
  assign x_init   = fold ? -m0 : m0;
  assign z_init   = fold ? a_wide - HalfTurn : a_wide;

  logic [DW-1:0] x_rot, y_rot;
  logic [AW-1:0] z_rot;

  cordic_stage #(
    .DW(DW),
    .AW(AW)
  ) u_stage (
    .x    (x_q),
    .y    (y_q),
    .z    (z_q),
    .idx  (iter_q[2:0]),
    .x_rot(x_rot),
    .y_rot(y_rot),
    .z_rot(z_rot)
  );

  // Round to integer with one guard bit so the +8 bias cannot wrap.
  logic signed [DW:0] x_rnd, y_rnd;

  assign x_rnd = ((DW + 1)'(x_q) + RoundBias) >>> FRAC;
  assign y_rnd = ((DW + 1)'(y_q) + RoundBias) >>> FRAC;

  function automatic logic [8:0] sat9(input logic signed [DW:0] v);
    if (v > SatHi) return 9'd255;
    if (v < SatLo) return 9'h101;
    return v[8:0];
  endfunction

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    z_d       = z_q;
    iter_d    = iter_q;
    x_out_d   = x_out_q;
    y_out_d   = y_out_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_d = StIter;
          x_d     = x_init;
          y_d     = '0;
          z_d     = z_init;
          iter_d  = '0;
        end
      end
      StIter: begin
        // The cycle after the last micro-rotation rounds and saturates the settled x/y.
        if (iter_q == LastIter) begin
          state_d = StDone;
          x_out_d = sat9(x_rnd);
          y_out_d = sat9(y_rnd);
        end else begin
          x_d    = x_rot;
          y_d    = y_rot;
          z_d    = z_rot;
          iter_d = iter_q + 4'd1;
        end
      end
      StDone: begin
        out_valid = 1'b1;
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      iter_q  <= '0;
      x_out_q <= '0;
      y_out_q <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      iter_q  <= iter_d;
      x_out_q <= x_out_d;
      y_out_q <= y_out_d;
    end
  end

  assign x_out = x_out_q;
  assign y_out = y_out_q;

endmodule
